// File: rtl/fft_radix4_sequencer.sv
// ============================================================================
//  Module      : fft_radix4_sequencer
//  Description : Address and control sequencer for an in-place radix-4 DIT
//                FFT. It walks every stage and butterfly of an N = 4^N_LOG4
//                point transform. Each cycle it issues four sample-RAM read
//                addresses and three twiddle exponents, and it replays the
//                read addresses as write-back addresses LAT cycles later.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_radix4_sequencer #(
    parameter int N_LOG4 = 3,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 1,
    parameter int ADDR_W = 2 * N_LOG4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N_LOG4-1:0] stage,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    output logic [ADDR_W-1:0] rd_addr3,
    output logic [ADDR_W-1:0] tw_addr1,
    output logic [ADDR_W-1:0] tw_addr2,
    output logic [ADDR_W-1:0] tw_addr3,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [ADDR_W-1:0] wr_addr1,
    output logic [ADDR_W-1:0] wr_addr2,
    output logic [ADDR_W-1:0] wr_addr3
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    // Read-to-write latency; the drain gap and the write-back delay both use it
    localparam int c_lat   = RD_LAT + BF_LAT;
    localparam int c_cnt_w = (c_lat > 1) ? $clog2(c_lat) : 1;
    localparam int c_dly_w = 4 * ADDR_W + 1;

    localparam logic [c_cnt_w-1:0] c_drain_last = c_cnt_w'(c_lat - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [ADDR_W-1:0]  c_one        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  c_quarter    = c_one << (ADDR_W - 2);
    localparam logic [ADDR_W-1:0]  c_k_last     = c_quarter - c_one;
    localparam logic [N_LOG4-1:0]  c_stage_last = N_LOG4'(N_LOG4 - 1);
    localparam logic [N_LOG4-1:0]  c_stage_one  = N_LOG4'(1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [ADDR_W-1:0]   r_k;
    logic [N_LOG4-1:0]   r_stage;
    logic [c_cnt_w-1:0]  r_drain_cnt;
    logic [4*ADDR_W-1:0] r_hold_rd;
    logic [3*ADDR_W-1:0] r_hold_tw;
    logic [c_dly_w-1:0]  r_dly [c_lat];

    logic [ADDR_W-1:0]   w_q;
    logic [ADDR_W-1:0]   w_j;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_stride;
    logic [ADDR_W-1:0]   w_tw1;
    logic                w_drain_end;

    assign w_drain_end = (r_drain_cnt == c_drain_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start is only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (start) w_state_nxt = c_run;
            c_run:   if (r_k == c_k_last) w_state_nxt = c_drain;
            c_drain: begin
                if (w_drain_end) begin
                    w_state_nxt = (r_stage == c_stage_last) ? c_done : c_run;
                end
            end
            c_done:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Butterfly index, stage index and drain-gap counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k         <= '0;
            r_stage     <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_k     <= '0;
                        r_stage <= '0;
                    end
                end
                c_run: begin
                    r_drain_cnt <= '0;
                    if (r_k != c_k_last) r_k <= r_k + c_one;
                end
                c_drain: begin
                    r_drain_cnt <= r_drain_cnt + c_cnt_one;
                    if (w_drain_end && (r_stage != c_stage_last)) begin
                        r_stage <= r_stage + c_stage_one;
                        r_k     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Butterfly geometry: q = 4^stage, j = k mod q, base = (k - j)*4 + j,
    // twiddle stride = (N/4) / q. Products never exceed 3N/4 so no wrap.
    always_comb begin
        w_q      = c_one << {r_stage, 1'b0};
        w_j      = r_k & (w_q - c_one);
        w_base   = ((r_k - w_j) << 2) + w_j;
        w_stride = c_quarter >> {r_stage, 1'b0};
        w_tw1    = w_j * w_stride;
    end

    // Moore outputs; addresses hold their previous value outside RUN
    always_comb begin
        busy  = (r_state == c_run) || (r_state == c_drain);
        done  = (r_state == c_done);
        rd_en = (r_state == c_run);
        stage = r_stage;
        if (r_state == c_run) begin
            rd_addr0 = w_base;
            rd_addr1 = w_base + w_q;
            rd_addr2 = w_base + (w_q << 1);
            rd_addr3 = w_base + (w_q << 1) + w_q;
            tw_addr1 = w_tw1;
            tw_addr2 = w_tw1 << 1;
            tw_addr3 = (w_tw1 << 1) + w_tw1;
        end else begin
            {rd_addr0, rd_addr1, rd_addr2, rd_addr3} = r_hold_rd;
            {tw_addr1, tw_addr2, tw_addr3}           = r_hold_tw;
        end
    end

    // Remember the last issued addresses so they stay stable while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_rd <= '0;
            r_hold_tw <= '0;
        end else begin
            r_hold_rd <= {rd_addr0, rd_addr1, rd_addr2, rd_addr3};
            r_hold_tw <= {tw_addr1, tw_addr2, tw_addr3};
        end
    end

    // Write-back delay line: in-place, so writes replay the reads LAT later
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_lat; i++) r_dly[i] <= '0;
        end else begin
            r_dly[0] <= {rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3};
            for (int i = 1; i < c_lat; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    // Tail of the delay line drives the RAM write port
    always_comb begin
        {wr_en, wr_addr0, wr_addr1, wr_addr2, wr_addr3} = r_dly[c_lat-1];
    end

endmodule

`default_nettype wire
